// File: rtl/multicycle_controller_if.sv
// Memory handshake bundle between the multicycle controller and the
// single memory port. The controller is the master: it raises the request
// (and the store qualifier) and the memory answers with mem_ready.
interface multicycle_controller_if;
    logic mem_req;
    logic mem_write;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM for a shared single-ALU, single-memory-port RV32I datapath.
// Sequences one instruction at a time: FETCH, DECODE, then a per-class
// execute path, stalling on the memory handshake and trapping on
// unsupported encodings.
// Optional feature macro: MC_PERF_CNT_EN enables cycle/instret counters;
// when undefined both counter ports are tied to 0 and no counter flops exist.
module multicycle_controller #(
    parameter int unsigned RESET_PC_HOLD = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [6:0]                     op,
    input  logic [2:0]                     funct3,
    input  logic                           funct7b5,
    input  logic                           zero,
    multicycle_controller_if.master        mem,
    output logic                           adr_src,
    output logic                           ir_write,
    output logic                           pc_write,
    output logic                           reg_write,
    output logic [1:0]                     alu_src_a,
    output logic [1:0]                     alu_src_b,
    output logic [1:0]                     result_src,
    output logic [1:0]                     imm_src,
    output logic [2:0]                     alu_control,
    output logic                           trap,
    output logic [31:0]                    cycle_count,
    output logic [31:0]                    instret_count
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    // Registered Moore outputs, loaded with the decode of the state being entered.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] imm_src;
        logic       trap;
    } ctrl_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [3:0] HOLD = 4'(RESET_PC_HOLD);

    state_t     state;
    state_t     state_next;
    ctrl_t      ctrl_q;
    logic [3:0] hold_cnt;
    logic       fetch_done;

    // Only the funct3 values the ALU decode supports are legal for R/I ops.
    function automatic logic alu_funct3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic state_t decode_target(input logic [6:0] opc, input logic [2:0] f3);
        case (opc)
            7'b0000011, 7'b0100011: return S_MEMADR;
            7'b0110011:             return alu_funct3_ok(f3) ? S_EXECR : S_ILLEGAL;
            7'b0010011:             return alu_funct3_ok(f3) ? S_EXECI : S_ILLEGAL;
            7'b1101111:             return S_JAL;
            7'b1100011:             return (f3 == 3'b000) ? S_BEQ : S_ILLEGAL;
            default:                return S_ILLEGAL;
        endcase
    endfunction

    // req_en is low only while the post-reset FETCH hold is still counting.
    function automatic ctrl_t moore_decode(input state_t s, input logic req_en, input logic store);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = req_en;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.imm_src   = 2'b10;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.imm_src   = store ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.mem_write = 1'b1;
                c.adr_src   = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = 2'b10;
            end
            S_EXECI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
            end
            S_ILLEGAL: begin
                c.trap = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // mem_ready only counts while a request is actually on the bus.
    assign fetch_done = (state == S_FETCH) && ctrl_q.mem_req && mem.mem_ready;

    // Next-state selection from the current state, opcode and handshake.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            S_FETCH:    if (fetch_done) state_next = S_DECODE;
            S_DECODE:   state_next = decode_target(op, funct3);
            S_MEMADR:   state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem.mem_ready) state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: if (mem.mem_ready) state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_BEQ:      state_next = S_FETCH;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            default:    state_next = S_ILLEGAL;
        endcase
    end

    // State, registered Moore outputs and the post-reset fetch hold counter.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state    <= S_FETCH;
            ctrl_q   <= '0;
            hold_cnt <= '0;
        end else begin
            state  <= state_next;
            ctrl_q <= moore_decode(state_next, hold_cnt == HOLD, op[5]);
            if (state == S_FETCH && hold_cnt != HOLD) hold_cnt <= hold_cnt + 4'd1;
        end
    end

    // ALU operation select; R/I decode by funct3, subtract for the branch compare.
    always_comb begin
        alu_control = ALU_ADD;
        case (state)
            S_EXECR, S_EXECI: begin
                case (funct3)
                    3'b000:  alu_control = (funct7b5 & op[5]) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            S_BEQ:   alu_control = ALU_SUB;
            default: alu_control = ALU_ADD;
        endcase
    end

    assign ir_write = fetch_done;
    assign pc_write = fetch_done || (state == S_JAL) || ((state == S_BEQ) && zero);

    assign mem.mem_req   = ctrl_q.mem_req;
    assign mem.mem_write = ctrl_q.mem_write;
    assign adr_src       = ctrl_q.adr_src;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign result_src    = ctrl_q.result_src;
    assign imm_src       = ctrl_q.imm_src;
    assign trap          = ctrl_q.trap;

`ifdef MC_PERF_CNT_EN
    logic retire;

    assign retire = (state_next == S_FETCH) &&
                    ((state == S_MEMWB) || (state == S_MEMWRITE) ||
                     (state == S_ALUWB) || (state == S_BEQ));

    // Free-running performance counters, frozen once the core has trapped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else if (state != S_ILLEGAL) begin
            cycle_count <= cycle_count + 32'd1;
            if (retire) instret_count <= instret_count + 32'd1;
        end
    end
`else
    assign cycle_count   = '0;
    assign instret_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Expected per-cycle control
// words are built from each instruction class's micro-sequence, with random
// memory wait states, operands and don't-care inputs.
module tb_multicycle_controller;

    localparam int HOLD = 2;
`ifdef MC_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] rs;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       trap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0;
    logic        zero = 1'b0;
    logic        adr_src, ir_write, pc_write, reg_write, trap;
    logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0]  alu_control;
    logic [31:0] cycle_count, instret_count;
    exp_t        obs;

    int checks = 0;
    int failures = 0;
    int exp_cyc = 0;
    int exp_ins = 0;

    multicycle_controller_if bus ();

    multicycle_controller #(.RESET_PC_HOLD(HOLD)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .op            (op),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem           (bus),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .imm_src       (imm_src),
        .alu_control   (alu_control),
        .trap          (trap),
        .cycle_count   (cycle_count),
        .instret_count (instret_count)
    );

    always #5 clk = ~clk;

    assign obs = {bus.mem_req, bus.mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, result_src, imm_src, alu_control, trap};

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic exp_t mk(input logic req, input logic wr, input logic adr,
                                input logic irw, input logic pcw, input logic rw,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [1:0] rs, input logic [1:0] imm,
                                input logic [2:0] alu, input logic tr);
        return {req, wr, adr, irw, pcw, rw, a, b, rs, imm, alu, tr};
    endfunction

    // ALU op expected while executing an R/I instruction.
    function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (f7 && o == 7'b0110011) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // One clock of checking: drive mem_ready, compare outputs and counters, advance.
    task automatic step(input exp_t e, input logic rdy, input bit frozen, input string tag);
        bus.mem_ready = rdy;
        #1;
        check({tag, " ctl"}, 64'(obs), 64'(e));
        check({tag, " cyc"}, 64'(cycle_count), PERF ? 64'(exp_cyc) : 64'd0);
        check({tag, " ret"}, 64'(instret_count), PERF ? 64'(exp_ins) : 64'd0);
        @(posedge clk);
        if (!frozen) exp_cyc++;
        @(negedge clk);
    endtask

    // Assert reset (called at a negedge or inside the low phase), check the
    // all-zero output state, release and walk through the fetch hold.
    task automatic do_reset();
        reset_n = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("reset ctl", 64'(obs), 64'd0);
        check("reset cyc", 64'(cycle_count), 64'd0);
        check("reset ret", 64'(instret_count), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_cyc = 0;
        exp_ins = 0;
        @(posedge clk);
        exp_cyc++;
        @(negedge clk);
        for (int k = 0; k < HOLD; k++)
            step(mk(0,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0), 1'b1, 1'b0,
                 $sformatf("hold[%0d]", k));
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw, input string name);
        exp_t q[$];
        logic r[$];
        logic [2:0] alu;
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        zero = z;
        alu = alu_of(o, f3, f7);
        for (int k = 0; k < fw; k++) begin
            q.push_back(mk(1,0,0,0,0,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0)); r.push_back(1'b0);
        end
        q.push_back(mk(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0)); r.push_back(1'b1);
        q.push_back(mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000, 0)); r.push_back(1'($urandom));
        case (o)
            7'b0000011: begin
                q.push_back(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 3'b000, 0)); r.push_back(1'($urandom));
                for (int k = 0; k < mw; k++) begin
                    q.push_back(mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0)); r.push_back(1'b0);
                end
                q.push_back(mk(1,0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0)); r.push_back(1'b1);
                q.push_back(mk(0,0,0,0,0,1, 2'b00,2'b00,2'b01,2'b00, 3'b000, 0)); r.push_back(1'($urandom));
            end
            7'b0100011: begin
                q.push_back(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b01, 3'b000, 0)); r.push_back(1'($urandom));
                for (int k = 0; k < mw; k++) begin
                    q.push_back(mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0)); r.push_back(1'b0);
                end
                q.push_back(mk(1,1,1,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0)); r.push_back(1'b1);
            end
            7'b0110011: begin
                q.push_back(mk(0,0,0,0,0,0, 2'b10,2'b00,2'b00,2'b00, alu, 0)); r.push_back(1'($urandom));
                q.push_back(mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0)); r.push_back(1'($urandom));
            end
            7'b0010011: begin
                q.push_back(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, alu, 0)); r.push_back(1'($urandom));
                q.push_back(mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0)); r.push_back(1'($urandom));
            end
            7'b1101111: begin
                q.push_back(mk(0,0,0,0,1,0, 2'b01,2'b10,2'b00,2'b00, 3'b000, 0)); r.push_back(1'($urandom));
                q.push_back(mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 3'b000, 0)); r.push_back(1'($urandom));
            end
            default: begin
                q.push_back(mk(0,0,0,0,z,0, 2'b10,2'b00,2'b00,2'b00, 3'b001, 0)); r.push_back(1'($urandom));
            end
        endcase
        for (int k = 0; k < q.size(); k++)
            step(q[k], r[k], 1'b0, $sformatf("%s[%0d]", name, k));
        exp_ins++;
    endtask

    // Fetch and decode an unsupported encoding, then watch the trap hold.
    task automatic run_illegal(input logic [6:0] o, input logic [2:0] f3, input int n, input string name);
        op = o;
        funct3 = f3;
        step(mk(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0), 1'b1, 1'b0, {name, " fetch"});
        step(mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000, 0), 1'b0, 1'b0, {name, " decode"});
        for (int k = 0; k < n; k++)
            step(mk(0,0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 3'b000, 1), 1'($urandom), 1'b1,
                 $sformatf("%s trap[%0d]", name, k));
    endtask

    initial begin
        logic [2:0] legal_f3 [4];
        logic [6:0] cls_op [6];
        int         cls;
        logic [2:0] f3;
        legal_f3 = '{3'b000, 3'b010, 3'b110, 3'b111};
        cls_op   = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        bus.mem_ready = 1'b0;

        @(negedge clk);
        do_reset();

        // Directed cases from the plan.
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2, "lw_wait2");
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, "beq_taken");
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, "beq_not");
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, "sub");
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, "addi_f7");
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, "jal");
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1, 1, "sw_wait");

        // Random mix of legal instructions with random wait states.
        for (int n = 0; n < 40; n++) begin
            cls = int'($urandom_range(0, 5));
            if (cls == 2 || cls == 3) f3 = legal_f3[$urandom_range(0, 3)];
            else if (cls == 5)        f3 = 3'b000;
            else                      f3 = 3'($urandom);
            run_instr(cls_op[cls], f3, 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      $sformatf("rnd%0d", n));
        end

        // Reset in the middle of a stalled store.
        op = 7'b0100011;
        funct3 = 3'b010;
        step(mk(1,0,0,1,1,0, 2'b00,2'b10,2'b10,2'b00, 3'b000, 0), 1'b1, 1'b0, "mid_sw fetch");
        step(mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b10, 3'b000, 0), 1'b0, 1'b0, "mid_sw decode");
        step(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b01, 3'b000, 0), 1'b0, 1'b0, "mid_sw memadr");
        bus.mem_ready = 1'b0;
        #1;
        check("mid_sw write before", 64'({bus.mem_req, bus.mem_write}), 64'b11);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_sw write dropped", 64'({bus.mem_req, bus.mem_write}), 64'b00);
        do_reset();
        run_instr(7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, "ori_after_rst");
        run_instr(7'b0110011, 3'b111, 1'b1, 1'b0, 2, 0, "and_after_rst");

        // Unsupported opcode: sticky trap, nothing issued, counters frozen.
        run_illegal(7'b0110111, 3'b000, 100, "lui");
        do_reset();

        // Unsupported funct3 on R-type and on branch.
        run_illegal(7'b0110011, 3'b001, 5, "r_f3");
        do_reset();
        run_illegal(7'b1100011, 3'b001, 5, "bne");
        do_reset();
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, "lw_final");
        run_instr(7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0, "slt_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM that sequences the shared single-ALU, single-memory-port RV32I datapath one instruction at a time. It issues ALU/mux selects, register-file write enable, PC/IR write enables and memory requests from the instruction opcode fields and the ALU zero flag. It stalls on a memory ready handshake and traps on unsupported encodings. It sits beside the datapath and is the only source of its control inputs.

## Interface
- `RESET_PC_HOLD`, default 0: extra cycles held in FETCH after reset release before the first `mem_req` (0–15).
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `op` in 7: `instr[6:0]` from the IR.
- `funct3` in 3: `instr[14:12]`.
- `funct7b5` in 1: `instr[30]`.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request; held until `mem_ready`.
- `mem_write` out 1: the request is a store.
- `adr_src` out 1: 0 = PC, 1 = ALU-out register.
- `ir_write` out 1: load the IR and old-PC register.
- `pc_write` out 1: load the PC from the result bus.
- `reg_write` out 1: register-file write enable.
- `alu_src_a` out 2: 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b` out 2: 00 = rs2, 01 = imm, 10 = constant 4.
- `result_src` out 2: 00 = ALU-out register, 01 = read data, 10 = ALU result.
- `imm_src` out 2: 00 = I, 01 = S, 10 = B, 11 = J.
- `alu_control` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `trap` out 1: an illegal instruction was decoded (sticky).
- `cycle_count` out 32: performance counter.
- `instret_count` out 32: performance counter.

## Operation
- **State encoding** (4-bit): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10, ILLEGAL 11.
- **Output style:** outputs are Moore decodes of the state, except `pc_write`, `ir_write` and `alu_control`. Any output not listed for a state is 0.
- **FETCH:** `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `result_src`=10.
  - On `mem_ready`: `ir_write`=1, `pc_write`=1, go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE:** `alu_src_a`=01, `alu_src_b`=01, `imm_src`=10 (computes the branch target). Next state by `op`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100011 with `funct3`=000 → BEQ
  - else → ILLEGAL
- **MEMADR:** `alu_src_a`=10, `alu_src_b`=01, `imm_src`=00 for loads and 01 for stores. `op[5]` selects MEMWRITE (1) or MEMREAD (0).
- **MEMREAD:** `mem_req`=1, `adr_src`=1. Hold until `mem_ready`, then go to MEMWB.
- **MEMWB:** `result_src`=01, `reg_write`=1, then FETCH.
- **MEMWRITE:** `mem_req`=1, `mem_write`=1, `adr_src`=1. Hold until `mem_ready`, then FETCH.
- **EXECR:** `alu_src_a`=10, `alu_src_b`=00, then ALUWB.
- **EXECI:** `alu_src_a`=10, `alu_src_b`=01, `imm_src`=00, then ALUWB.
- **ALUWB:** `result_src`=00, `reg_write`=1, then FETCH.
- **JAL:** `alu_src_a`=01, `alu_src_b`=10, `result_src`=00, `pc_write`=1, then ALUWB (writes PC+4 to rd).
- **BEQ:** `alu_src_a`=10, `alu_src_b`=00, `alu_control`=sub, `result_src`=00, `pc_write`=`zero`, then FETCH.
- **ILLEGAL:** `trap`=1, all other outputs 0. Absorbing; only reset exits.
- **ALU decode:**
  - add in FETCH, DECODE, MEMADR, JAL.
  - In EXECR/EXECI, by `funct3`:
    - 000 → sub if (`funct7b5` & `op[5]`), else add
    - 010 → slt
    - 110 → or
    - 111 → and
  - Any other `funct3` in EXECR/EXECI is detected in DECODE and sent to ILLEGAL.

## Timing
- **Reset:** asynchronous assert forces state FETCH, hold counter 0, `trap` 0 and counters 0. While `reset_n`=0, all outputs are 0.
- **After reset release:** the FSM waits `RESET_PC_HOLD` cycles in FETCH with `mem_req`=0, then asserts `mem_req`.
- **Instruction latency** with zero-wait memory (`mem_ready` high in the same cycle as `mem_req`):
  - lw 5 cycles
  - sw 4, R/I 4, jal 4, beq 3
- Each memory wait cycle adds 1 cycle.
- **Handshake:** `mem_req`, `mem_write` and `adr_src` are stable from the request cycle through the `mem_ready` cycle. `mem_ready` while `mem_req`=0 is ignored.
- **Reset mid-operation:** reset asserted during MEMWRITE with `mem_ready` low drops `mem_req`/`mem_write` immediately (asynchronously). No write is committed by this block.
- `pc_write` and `ir_write` never assert in the same cycle as `reg_write`.

## Configuration
- Macro `MC_PERF_CNT_EN`.
- **Defined:**
  - `cycle_count` increments every cycle after reset.
  - `instret_count` increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - Both wrap from 0xFFFFFFFF to 0.
  - Both freeze while in ILLEGAL.
- **Undefined:** both ports are constant 0 and no counter flops exist.

## Test plan
- **lw, 2-cycle read wait:** `op`=0000011, `mem_ready` low 2 cycles in MEMREAD → state path 0,1,2,3,3,3,4,0; `reg_write`=1 only in MEMWB with `result_src`=01.
- **beq:** `op`=1100011, `funct3`=000.
  - `zero`=1 → `pc_write`=1 in BEQ, `alu_control`=001.
  - `zero`=0 → `pc_write`=0; both cases 3 cycles.
- **R-type sub:** `op`=0110011, `funct3`=000, `funct7b5`=1 → `alu_control`=001 in EXECR. With `op`=0010011 and `funct7b5`=1 → add (000).
- **jal:** `op`=1101111 → JAL asserts `pc_write` with `alu_src_b`=10, then ALUWB `reg_write`=1; 4 cycles total.
- **Illegal:** `op`=0110111 → ILLEGAL; `trap`=1 persists 100 cycles with `mem_req`=0; `instret_count` frozen.
- **Reset mid-store, perf counters:** deassert `reset_n` during MEMWRITE with `mem_ready`=0 → `mem_write`=0 the same cycle. After release the FSM is in FETCH and, with `MC_PERF_CNT_EN`, `cycle_count` restarts at 0.
